// File: rtl/softmax_pkg.sv
// softmax_pkg: Q-format constants, FSM state encoding and saturation shared by the softmax row unit.
package softmax_pkg;
  localparam int Q_W = 16;
  localparam int Q_FRAC = 8;
  localparam logic [Q_W-1:0] ONE = Q_W'(1 << Q_FRAC);
  localparam logic signed [Q_W-1:0] MIN_VAL = {1'b1, {(Q_W-1){1'b0}}};
  localparam logic signed [Q_W-1:0] MAX_VAL = {1'b0, {(Q_W-1){1'b1}}};
  typedef enum logic [4:0] {
    S_IDLE = 5'b00001,
    S_MAX  = 5'b00010,
    S_SUM  = 5'b00100,
    S_DIV  = 5'b01000,
    S_OUT  = 5'b10000
  } state_t;
  function automatic logic signed [Q_W-1:0] sat_q(input logic signed [Q_W:0] v);
    return (v[Q_W] != v[Q_W-1]) ? (v[Q_W] ? MIN_VAL : MAX_VAL) : v[Q_W-1:0];
  endfunction
endpackage

// File: rtl/softmax_div_unit.sv
// softmax_div_unit: restoring divider, (dividend << FRAC_W) / divisor, one quotient bit per cycle.
module softmax_div_unit #(
  parameter int D_W    = 16,
  parameter int FRAC_W = 8,
  parameter int SUM_W  = 20
) (
  input  logic             I_CLK,
  input  logic             I_RST_N,
  input  logic             start,
  input  logic [D_W-1:0]   dividend,
  input  logic [SUM_W-1:0] divisor,
  output logic             done,
  output logic [D_W:0]     quotient
);
  localparam int CW = $clog2(D_W + 1);
  logic [D_W+FRAC_W-1:0] num;
  logic [SUM_W-1:0] rem, dvs, rem_in, dvs_in, rem_nx;
  logic [D_W:0] sh, sh_in;
  logic [SUM_W:0] trial;
  logic [CW-1:0] cnt;
  logic busy, ge;
  // the start cycle already performs the first step, so done lands D_W+1 cycles after start
  always_comb begin
    num = {dividend, {FRAC_W{1'b0}}};
    rem_in = start ? SUM_W'(num >> (D_W + 1)) : rem;
    sh_in = start ? num[D_W:0] : sh;
    dvs_in = start ? divisor : dvs;
    trial = {rem_in, sh_in[D_W]};
    ge = trial >= {1'b0, dvs_in};
    rem_nx = ge ? SUM_W'(trial - {1'b0, dvs_in}) : trial[SUM_W-1:0];
  end
  always_ff @(posedge I_CLK or negedge I_RST_N)
    if (!I_RST_N) begin
      rem <= '0;
      dvs <= '0;
      sh <= '0;
      cnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= busy && !start && cnt == CW'(1);
      if (start) begin
        rem <= rem_nx;
        sh <= {sh_in[D_W-1:0], ge};
        dvs <= divisor;
        cnt <= CW'(D_W);
        busy <= 1'b1;
      end else if (busy) begin
        rem <= rem_nx;
        sh <= {sh_in[D_W-1:0], ge};
        cnt <= cnt - 1'b1;
        busy <= cnt != CW'(1);
      end
    end
  assign quotient = sh;
endmodule

// File: rtl/softmax_exp_unit.sv
// softmax_exp_unit: combinational exp(x) for x <= 0 in Q8.8, via 2^(x*log2 e) with a quadratic 2^-f fit.
module softmax_exp_unit
  import softmax_pkg::*;
(
  input  logic signed [Q_W-1:0] x,
  output logic        [Q_W-1:0] y
);
  logic signed [31:0] xs;
  logic [31:0] t, p, yq, n, f, m;
  always_comb begin
    xs = 32'(x);
    t = xs[31] ? 32'(-xs) : '0;
    p = t * 32'd1477;
    yq = p >> 10;
    n = yq >> 8;
    f = {24'd0, yq[7:0]};
    // m is 2^-f in Q16, exact at f=0 and f=1
    m = 32'd65536 - 32'd172 * f + ((32'd44 * f * f) >> 8);
    y = (n > 32'd16) ? '0 : Q_W'(m >> (n + 32'd8));
  end
endmodule

// File: rtl/softmax_stream.sv
// softmax_stream: masked safe softmax over one row of NUM Q-format scores, valid/ready in and out.
module softmax_stream
  import softmax_pkg::*;
#(
  parameter int D_W    = 16,
  parameter int FRAC_W = 8,
  parameter int NUM    = 16
) (
  input  logic               I_CLK,
  input  logic               I_RST_N,
  input  logic               I_VLD,
  output logic               O_RDY,
  input  logic [D_W*NUM-1:0] I_DATA,
  input  logic [NUM-1:0]     I_MASK,
  output logic               O_VLD,
  input  logic               I_RDY,
  output logic [D_W*NUM-1:0] O_DATA,
  output logic               O_ALLMASK
);
  localparam int SUM_W = D_W + $clog2(NUM);
  localparam int EW = $clog2(NUM);
  localparam int IW = EW + 1;
  localparam logic [IW-1:0] LAST = IW'(NUM - 1);
  localparam logic [IW-1:0] ENDI = IW'(NUM);
  state_t state, nxt;
  logic [NUM-1:0][D_W-1:0] row, ebuf;
  logic [NUM-1:0] msk;
  logic signed [D_W-1:0] mx, x, diff;
  logic [D_W:0] d17, q;
  logic [D_W-1:0] e, qs;
  logic [SUM_W-1:0] sum;
  logic [IW-1:0] idx;
  logic [EW-1:0] ie;
  logic rdy, wt, allm, accept, last, skip, div_start, div_done;
  always_comb begin
    ie = idx[EW-1:0];
    x = row[ie];
    d17 = {x[D_W-1], x} - {mx[D_W-1], mx};
    diff = sat_q(d17);
    last = idx == LAST;
    accept = I_VLD && rdy;
    skip = msk[ie] || sum == '0;
    div_start = state == S_DIV && idx != ENDI && !skip && !wt;
    qs = (q > (D_W+1)'(ONE)) ? ONE : q[D_W-1:0];
    nxt = state;
    case (state)
      S_IDLE: nxt = accept ? S_MAX : S_IDLE;
      S_MAX:  nxt = last ? S_SUM : S_MAX;
      S_SUM:  nxt = last ? S_DIV : S_SUM;
      S_DIV:  nxt = (idx == ENDI) ? S_OUT : S_DIV;
      S_OUT:  nxt = I_RDY ? S_IDLE : S_OUT;
      default: nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge I_CLK or negedge I_RST_N)
    if (!I_RST_N) state <= S_IDLE;
    else state <= nxt;
  // ebuf holds exp values during S_SUM and is overwritten in place by the probabilities
  always_ff @(posedge I_CLK or negedge I_RST_N)
    if (!I_RST_N) begin
      rdy <= 1'b0;
      row <= '0;
      msk <= '0;
      mx <= '0;
      sum <= '0;
      idx <= '0;
      ebuf <= '0;
      wt <= 1'b0;
      allm <= 1'b0;
    end else begin
      rdy <= nxt == S_IDLE;
      case (state)
        S_IDLE: if (accept) begin
          row <= I_DATA;
          msk <= I_MASK;
          mx <= MIN_VAL;
          sum <= '0;
          idx <= '0;
          wt <= 1'b0;
          allm <= 1'b0;
        end
        S_MAX: begin
          if (!msk[ie] && x > mx) mx <= x;
          idx <= last ? '0 : idx + 1'b1;
        end
        S_SUM: begin
          ebuf[ie] <= msk[ie] ? '0 : e;
          sum <= msk[ie] ? sum : sum + SUM_W'(e);
          idx <= last ? '0 : idx + 1'b1;
        end
        S_DIV: if (idx == ENDI) allm <= sum == '0;
          else if (skip) begin
            ebuf[ie] <= '0;
            idx <= idx + 1'b1;
          end else if (!wt) wt <= 1'b1;
          else if (div_done) begin
            ebuf[ie] <= qs;
            wt <= 1'b0;
            idx <= idx + 1'b1;
          end
        default: ;
      endcase
    end
  softmax_exp_unit u_exp (.x(diff), .y(e));
  softmax_div_unit #(.D_W(D_W), .FRAC_W(FRAC_W), .SUM_W(SUM_W)) u_div (
    .I_CLK(I_CLK),
    .I_RST_N(I_RST_N),
    .start(div_start),
    .dividend(ebuf[ie]),
    .divisor(sum),
    .done(div_done),
    .quotient(q)
  );
  assign O_RDY = rdy;
  assign O_VLD = state == S_OUT;
  assign O_DATA = ebuf;
  assign O_ALLMASK = allm;
endmodule

// File: tb/tb_softmax_stream.sv
// tb_softmax_stream: scoreboard bench for softmax_stream (NUM=4), real-valued exp reference model.
module tb_softmax_stream;
  logic clk, rst_n, I_VLD, O_RDY, O_VLD, I_RDY, O_ALLMASK;
  logic [63:0] I_DATA, O_DATA;
  logic [3:0] I_MASK;
  int checks = 0, errors = 0, cyc = 0, nrow = 0, starts = 0, hs_cyc = 0, last_acc = 0;
  bit bp_rand = 0, rdy_force = 1;

  typedef struct {
    int id;
    int acc;
    int lat;
    int tol;
    int allm;
    int q[4];
  } exp_t;
  exp_t sb[$];

  softmax_stream #(.D_W(16), .FRAC_W(8), .NUM(4)) dut (
    .I_CLK(clk), .I_RST_N(rst_n), .I_VLD(I_VLD), .O_RDY(O_RDY), .I_DATA(I_DATA),
    .I_MASK(I_MASK), .O_VLD(O_VLD), .I_RDY(I_RDY), .O_DATA(O_DATA), .O_ALLMASK(O_ALLMASK)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (dut.div_start) starts <= starts + 1;
  always @(negedge clk) I_RDY = bp_rand ? 1'($urandom_range(0, 1)) : rdy_force;

  task automatic chk(input string nm, input int act, input int req, input int tol);
    checks++;
    if (act > req + tol || act < req - tol) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d) at cycle %0d", nm, act, req, tol, cyc);
    end
  endtask

  // safe softmax from first principles: max over unmasked, real exp, truncated ratio
  function automatic exp_t model(input logic [63:0] d, input logic [3:0] m, input int tol);
    exp_t r;
    int x[4], e[4];
    int mx = -32768, sum = 0, nu = 0, df;
    for (int i = 0; i < 4; i++) begin
      x[i] = int'($signed(d[16*i +: 16]));
      if (!m[i]) begin
        nu++;
        if (x[i] > mx) mx = x[i];
      end
    end
    for (int i = 0; i < 4; i++) begin
      df = x[i] - mx;
      if (df < -32768) df = -32768;
      e[i] = m[i] ? 0 : $rtoi($floor(256.0 * $exp(real'(df) / 256.0)));
      sum += e[i];
    end
    for (int i = 0; i < 4; i++)
      r.q[i] = (sum == 0) ? 0 : ((e[i] * 256 / sum > 256) ? 256 : e[i] * 256 / sum);
    r.allm = (sum == 0) ? 1 : 0;
    r.lat = 2 * 4 + nu * 18 + (4 - nu) + 1;
    r.tol = tol;
    r.id = 0;
    r.acc = 0;
    return r;
  endfunction

  task automatic send(input logic [63:0] d, input logic [3:0] m, input int tol);
    exp_t it;
    int k;
    it = model(d, m, tol);
    it.id = nrow++;
    I_DATA = d;
    I_MASK = m;
    I_VLD = 1;
    for (k = 0; k < 3000; k++) begin
      #1;
      if (O_RDY) break;
      @(negedge clk);
    end
    if (k == 3000) chk("accept_timeout", 0, 1, 0);
    else begin
      it.acc = cyc + 1;
      last_acc = cyc + 1;
      sb.push_back(it);
    end
    @(negedge clk);
    I_VLD = 0;
    I_DATA = {$urandom, $urandom};
    I_MASK = 4'($urandom);
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 3000; k++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    if (k == 3000) chk("drain_timeout", 0, 1, 0);
    @(negedge clk);
  endtask

  // monitor: samples mid-cycle, checks hold stability and pops the scoreboard on each output handshake
  initial begin
    exp_t it;
    int rise = 0;
    bit pv = 0;
    logic [63:0] held = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        pv = 0;
        continue;
      end
      if (O_VLD && !pv) begin
        rise = cyc;
        held = O_DATA;
      end
      if (O_VLD && pv) chk("hold_stable", int'(O_DATA != held), 0, 0);
      if (O_VLD && I_RDY) begin
        hs_cyc = cyc + 1;
        if (sb.size() == 0) chk("unexpected_output", 1, 0, 0);
        else begin
          it = sb.pop_front();
          for (int i = 0; i < 4; i++)
            chk($sformatf("row%0d_elem%0d", it.id, i), int'(O_DATA[16*i +: 16]), it.q[i], it.tol);
          chk($sformatf("row%0d_allmask", it.id), int'(O_ALLMASK), it.allm, 0);
          chk($sformatf("row%0d_latency", it.id), rise - it.acc, it.lat, 0);
        end
      end
      pv = O_VLD && !I_RDY;
    end
  end

  initial begin
    logic [63:0] rd;
    logic [3:0] rm;
    int s0, k;
    rst_n = 0;
    I_VLD = 0;
    I_DATA = '0;
    I_MASK = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ordy", int'(O_RDY), 0, 0);
    chk("rst_ovld", int'(O_VLD), 0, 0);
    chk("rst_odata_nonzero", int'(O_DATA != '0), 0, 0);
    chk("rst_allmask", int'(O_ALLMASK), 0, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    #1;
    chk("ordy_after_release", int'(O_RDY), 1, 0);

    send(64'h0, 4'b0000, 2);
    drain();
    send({4{16'h0100}}, 4'b0000, 2);
    send({4{16'h7F00}}, 4'b0000, 2);
    drain();
    s0 = starts;
    send(64'h0, 4'b0101, 2);
    drain();
    chk("mask_div_starts", starts - s0, 2, 0);
    s0 = starts;
    send(64'h0, 4'b1111, 2);
    drain();
    chk("allmask_div_starts", starts - s0, 0, 0);

    rdy_force = 0;
    repeat (2) @(negedge clk);
    send({16'h0300, 16'h0200, 16'h0100, 16'h0000}, 4'b0000, 2);
    for (k = 0; k < 500; k++) begin
      @(negedge clk);
      #1;
      if (O_VLD) break;
    end
    if (k == 500) chk("ovld_timeout", 0, 1, 0);
    I_DATA = {16'h0000, 16'hFF00, 16'h0080, 16'h0000};
    I_MASK = 4'b0010;
    I_VLD = 1;
    repeat (20) begin
      @(negedge clk);
      #1;
      chk("busy_ordy", int'(O_RDY), 0, 0);
      chk("bp_ovld", int'(O_VLD), 1, 0);
    end
    rdy_force = 1;
    send({16'h0000, 16'hFF00, 16'h0080, 16'h0000}, 4'b0010, 2);
    chk("b2b_accept_gap", last_acc - hs_cyc, 1, 0);
    drain();

    send(64'h0, 4'b0000, 2);
    repeat (20) @(negedge clk);
    sb.delete();
    rst_n = 0;
    #1;
    chk("midrst_ovld", int'(O_VLD), 0, 0);
    chk("midrst_ordy", int'(O_RDY), 0, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    #1;
    chk("midrst_ordy_release", int'(O_RDY), 1, 0);
    send(64'h0, 4'b0000, 2);
    drain();

    bp_rand = 1;
    repeat (20) begin
      for (int i = 0; i < 4; i++)
        rd[16*i +: 16] = ($urandom_range(0, 7) == 0) ? ($urandom_range(0, 1) ? 16'h7FFF : 16'h8000)
                                                     : 16'($urandom_range(0, 4095) - 2048);
      rm = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      send(rd, rm, 4);
    end
    drain();
    bp_rand = 0;
    rdy_force = 1;
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
